// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - host-side TX word handshake bundle
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX sequencer driving an external LSB-first shift register
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_ctrl_if.slave        host,
  output logic                 sr_load,
  output logic [DATA_BITS-1:0] sr_data_p,
  output logic                 sr_shift,
  input  logic                 sr_bit,
  output logic                 tx,
  output logic                 busy
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                ready_q, ready_d;
  logic                parity_q, parity_d;
  logic                accept;
  logic                bit_end;

  assign accept  = host.tx_valid && ready_q;
  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      ready_q  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      ready_q  <= ready_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && bit_q == DATA_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && bit_q == STOP_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Both counters restart on every state change so each state times itself from zero.
    baud_d = baud_q;
    bit_d  = bit_q;
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
    end else if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
      if (bit_end && (state_q == S_DATA || state_q == S_STOP)) bit_d = bit_q + 1'b1;
    end

    ready_d  = (state_q == S_IDLE) && !accept;
    parity_d = accept ? ((^host.tx_data) ^ (PARITY_ODD != 0)) : parity_q;
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START:  tx = 1'b0;
      S_DATA:   tx = sr_bit;
      S_PARITY: tx = parity_q;
      default:  tx = 1'b1;
    endcase
    busy     = (state_q != S_IDLE);
    sr_shift = (state_q == S_DATA) && bit_end;
    sr_load  = accept;
  end

  assign sr_data_p     = host.tx_data;
  assign host.tx_ready = ready_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl across four configurations
module tb_uart_tx_ctrl;
  localparam int CPBA [4] = '{4, 4, 4, 3};
  localparam int DBA  [4] = '{8, 8, 8, 5};
  localparam int PENA [4] = '{0, 1, 1, 0};
  localparam int PODA [4] = '{0, 0, 1, 0};
  localparam int STA  [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] din [4];
  logic       vin [4];
  wire        rdy [4];
  wire        txo [4];
  wire        bsy [4];
  wire        ld  [4];
  wire        sh  [4];
  wire  [8:0] pdw [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gi
    logic [DBA[g]-1:0] pd;
    logic              ldl, shl;
    logic [8:0]        srq;
    uart_tx_ctrl_if #(.DATA_BITS(DBA[g])) bus ();
    assign bus.tx_data  = din[g][DBA[g]-1:0];
    assign bus.tx_valid = vin[g];
    uart_tx_ctrl #(
      .CLKS_PER_BIT(CPBA[g]), .DATA_BITS(DBA[g]), .PARITY_EN(PENA[g]),
      .PARITY_ODD(PODA[g]), .STOP_BITS(STA[g])
    ) dut (
      .clk(clk), .rst_n(rst_n), .host(bus.slave),
      .sr_load(ldl), .sr_data_p(pd), .sr_shift(shl), .sr_bit(srq[0]),
      .tx(txo[g]), .busy(bsy[g])
    );
    assign rdy[g] = bus.tx_ready;
    assign ld[g]  = ldl;
    assign sh[g]  = shl;
    assign pdw[g] = 9'(pd);
    always_ff @(posedge clk) begin
      if (ldl) srq <= 9'(pd);
      else if (shl) srq <= srq >> 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame: line bits in transmit order, one entry per bit period.
  function automatic logic [15:0] frame_bits(input int i, input logic [8:0] d, output int nb);
    logic [15:0] b;
    logic        par;
    int          p;
    b   = '0;
    par = (PODA[i] != 0);
    for (int k = 0; k < DBA[i]; k++) begin
      b[1+k] = d[k];
      par    = par ^ d[k];
    end
    p = 1 + DBA[i];
    if (PENA[i] != 0) begin
      b[p] = par;
      p++;
    end
    for (int s = 0; s < STA[i]; s++) begin
      b[p] = 1'b1;
      p++;
    end
    nb = p;
    return b;
  endfunction

  task automatic send(input int i, input logic [8:0] d, input logic [15:0] bits, input int nb,
                      input string nm, input bit hold, input logic [8:0] nxt, input bit glitch,
                      output int waited);
    int         cpb, db, len, wave_err, sh_err, nsh, nld, st_err, idx;
    logic       exp_sh;
    logic [8:0] mask;
    cpb = CPBA[i]; db = DBA[i]; len = nb * cpb;
    wave_err = 0; sh_err = 0; nsh = 0; nld = 0; st_err = 0;
    mask = 9'((1 << db) - 1);
    waited = 0;
    while (!rdy[i] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check({nm, "_ready_before"}, 32'(rdy[i]), 32'd1);
    din[i] = d;
    vin[i] = 1'b1;
    #1;
    check({nm, "_sr_load"}, 32'(ld[i]), 32'd1);
    check({nm, "_sr_data_p"}, 32'(pdw[i] & mask), 32'(d & mask));
    @(negedge clk);
    if (hold) din[i] = nxt;
    else vin[i] = 1'b0;
    for (int c = 0; c < len; c++) begin
      idx    = c / cpb;
      exp_sh = (idx >= 1) && (idx <= db) && ((c % cpb) == cpb - 1);
      if (txo[i] !== bits[idx]) wave_err++;
      if (sh[i] !== exp_sh) sh_err++;
      if (sh[i] === 1'b1) nsh++;
      if (ld[i] !== 1'b0) nld++;
      if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1) st_err++;
      if (glitch && c == len / 2) begin
        vin[i] = 1'b1;
        din[i] = ~d;
      end
      if (glitch && c == len / 2 + 3) vin[i] = 1'b0;
      @(negedge clk);
    end
    check({nm, "_tx_wave_errs"}, 32'(wave_err), 32'd0);
    check({nm, "_shift_timing_errs"}, 32'(sh_err), 32'd0);
    check({nm, "_shift_count"}, 32'(nsh), 32'(db));
    check({nm, "_load_while_busy"}, 32'(nld), 32'd0);
    check({nm, "_busy_ready_errs"}, 32'(st_err), 32'd0);
    check({nm, "_idle_tx"}, 32'(txo[i]), 32'd1);
    check({nm, "_idle_busy"}, 32'(bsy[i]), 32'd0);
    check({nm, "_idle_ready"}, 32'(rdy[i]), 32'd0);
    check({nm, "_idle_load"}, 32'(ld[i]), 32'd0);
  endtask

  typedef struct {
    int          inst;
    logic [8:0]  data;
    logic [15:0] bits;
    int          nb;
    bit          hold;
    bit          glitch;
    string       name;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          w, nb;
    logic [8:0]  d;
    logic [15:0] b;

    tbl[0] = '{0, 9'h0A5, 16'h034A, 10, 1'b0, 1'b0, "a5"};
    tbl[1] = '{1, 9'h007, 16'h060E, 11, 1'b0, 1'b0, "par_even_07"};
    tbl[2] = '{2, 9'h007, 16'h040E, 11, 1'b0, 1'b0, "par_odd_07"};
    tbl[3] = '{1, 9'h000, 16'h0400, 11, 1'b0, 1'b0, "par_even_00"};
    tbl[4] = '{3, 9'h015, 16'h00EA,  8, 1'b0, 1'b0, "db5_stop2_15"};
    tbl[5] = '{0, 9'h001, 16'h0202, 10, 1'b1, 1'b0, "b2b_01"};
    tbl[6] = '{0, 9'h0FF, 16'h03FE, 10, 1'b1, 1'b0, "b2b_ff"};
    tbl[7] = '{0, 9'h03C, 16'h0278, 10, 1'b0, 1'b0, "b2b_3c"};
    tbl[8] = '{0, 9'h0C3, 16'h0386, 10, 1'b0, 1'b1, "glitch_c3"};

    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b0;
      din[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), 32'(txo[i]), 32'd1);
      check($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("rst_ctl%0d", i), 32'({ld[i], sh[i]}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("ready_after_rst%0d", i), 32'(rdy[i]), 32'd1);

    for (int k = 0; k < 9; k++) begin
      send(tbl[k].inst, tbl[k].data, tbl[k].bits, tbl[k].nb, tbl[k].name, tbl[k].hold,
           (k < 8) ? tbl[k+1].data : 9'h0, tbl[k].glitch, w);
      if (k > 0 && tbl[k-1].hold) check({tbl[k].name, "_gap_cycles"}, 32'(w), 32'd1);
    end

    // Reset during data bit 3 of a frame on the 8-bit, no-parity instance.
    while (!rdy[0]) @(negedge clk);
    din[0] = 9'h096;
    vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (4 * CPBA[0] + 1) @(negedge clk);
    check("pre_reset_busy", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(txo[0]), 32'd1);
    check("midrst_busy", 32'(bsy[0]), 32'd0);
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    check("rel_ready_first_edge", 32'(rdy[0]), 32'd1);
    send(0, 9'h05A, 16'h02B4, 10, "after_rst_5a", 1'b0, 9'h0, 1'b0, w);

    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 8; r++) begin
        d = 9'($urandom);
        b = frame_bits(i, d, nb);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(i, d, b, nb, $sformatf("rnd%0d_%0d", i, r), 1'b0, 9'h0, (r == 3), w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
